// File: rtl/plot_framebuffer.sv
// Plot-bus frame store (WIDTH x HEIGHT x COLOUR_W) with a valid/ready raster readout engine.
// Optional fill engine (clear_req/clear_colour, CLEAR state) is built when PLOT_FRAMEBUFFER_CLEAR_EN is defined.

module plot_framebuffer #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                plot,
    input  logic                scan_en,
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
`endif
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [7:0]          pix_x,
    output logic [6:0]          pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_last,
    output logic                busy
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [7:0]  X_END     = 8'(WIDTH);
    localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
    localparam logic [6:0]  Y_END     = 7'(HEIGHT);
    localparam logic [6:0]  Y_LAST    = 7'(HEIGHT - 1);
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
    localparam logic [14:0] ADDR_LAST = 15'(DEPTH - 1);
`endif

`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
    typedef enum logic [1:0] {IDLE, READ, PRESENT, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, PRESENT} state_t;
`endif

    state_t                state_q;
    logic [7:0]            cnt_x_q;
    logic [6:0]            cnt_y_q;
    logic                  pix_valid_q;
    logic [7:0]            pix_x_q;
    logic [6:0]            pix_y_q;
    logic                  pix_last_q;
    logic                  busy_q;
    logic [COLOUR_W-1:0]   rd_data_q;
    logic [COLOUR_W-1:0]   mem [0:DEPTH-1];

    logic                  wr_en_d;
    logic [14:0]           wr_addr_d;
    logic [COLOUR_W-1:0]   wr_data_d;
    logic                  rd_en_d;
    logic [14:0]           rd_addr_d;

`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
    logic [14:0]           clr_addr_q;
    logic [COLOUR_W-1:0]   clr_colour_q;
`endif

    function automatic logic [14:0] pix_addr(input logic [7:0] col, input logic [6:0] row);
        return 15'(row) * 15'(WIDTH) + 15'(col);
    endfunction

    always_comb begin
        wr_en_d   = plot && (x < X_END) && (y < Y_END);
        wr_addr_d = pix_addr(x, y);
        wr_data_d = colour;
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
        // The fill engine owns the write port; plot traffic is dropped meanwhile.
        if (state_q == CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_addr_q;
            wr_data_d = clr_colour_q;
        end
`endif
        rd_en_d   = (state_q == READ);
        rd_addr_d = pix_addr(cnt_x_q, cnt_y_q);
    end

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[wr_addr_d] <= wr_data_d;
        end
    end

    // Read only in READ so a held pixel cannot change if its address is rewritten.
    always_ff @(posedge clk) begin
        if (rd_en_d) begin
            rd_data_q <= mem[rd_addr_d];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_x_q     <= '0;
            cnt_y_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
            clr_addr_q   <= '0;
            clr_colour_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
                    if (clear_req) begin
                        state_q      <= CLEAR;
                        busy_q       <= 1'b1;
                        clr_addr_q   <= '0;
                        clr_colour_q <= clear_colour;
                    end else
`endif
                    if (scan_en) begin
                        state_q <= READ;
                        cnt_x_q <= '0;
                        cnt_y_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    state_q     <= PRESENT;
                    pix_valid_q <= 1'b1;
                    pix_x_q     <= cnt_x_q;
                    pix_y_q     <= cnt_y_q;
                    pix_last_q  <= (cnt_x_q == X_LAST) && (cnt_y_q == Y_LAST);
                end
                PRESENT: begin
                    if (pix_ready) begin
                        pix_valid_q <= 1'b0;
                        if (pix_last_q) begin
                            cnt_x_q <= '0;
                            cnt_y_q <= '0;
                            if (scan_en) begin
                                state_q <= READ;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            state_q <= READ;
                            if (cnt_x_q == X_LAST) begin
                                cnt_x_q <= '0;
                                cnt_y_q <= cnt_y_q + 7'd1;
                            end else begin
                                cnt_x_q <= cnt_x_q + 8'd1;
                            end
                        end
                    end
                end
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
                CLEAR: begin
                    if (clr_addr_q == ADDR_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 15'd1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_colour = pix_valid_q ? rd_data_q : '0;
    assign pix_last   = pix_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: writes, range drops, stall, collision, frame chaining, reset, optional clear.
module tb_plot_framebuffer;

    localparam int WIDTH    = 160;
    localparam int HEIGHT   = 120;
    localparam int COLOUR_W = 3;
    localparam int DEPTH    = WIDTH * HEIGHT;

    logic                clk = 1'b0;
    logic                resetn;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                scan_en;
    logic                pix_valid;
    logic                pix_ready;
    logic [7:0]          pix_x;
    logic [6:0]          pix_y;
    logic [COLOUR_W-1:0] pix_colour;
    logic                pix_last;
    logic                busy;
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
    logic                clear_req;
    logic [COLOUR_W-1:0] clear_colour;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plot_framebuffer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLOUR_W(COLOUR_W)) dut (
        .clk(clk),
        .resetn(resetn),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .scan_en(scan_en),
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
        .clear_req(clear_req),
        .clear_colour(clear_colour),
`endif
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_colour(pix_colour),
        .pix_last(pix_last),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until pix_valid is seen or the budget runs out; n = steps taken.
    task automatic wait_valid(output int n);
        n = 0;
        while (pix_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_plot(input int px, input int py, input int pc);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = COLOUR_W'(pc);
        step();
        plot   = 1'b0;
        $display("plot x=%0d y=%0d colour=%0d", px, py, pc);
    endtask

    function automatic int expected_colour(input int frame, input int idx);
        case (idx)
            0:     return 1;
            2:     return (frame == 1) ? 4 : 1;
            7:     return (frame == 1) ? 3 : 6;
            160:   return 2;
            485:   return 5;
            19199: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic test_reset();
        resetn = 1'b0; plot = 1'b0; scan_en = 1'b0; pix_ready = 1'b0;
        x = '0; y = '0; colour = '0;
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
        clear_req = 1'b0; clear_colour = '0;
`endif
        step(); step();
        checks++;
        if (pix_valid !== 1'b0 || pix_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b last=%b busy=%b required 0 0 0", pix_valid, pix_last, busy);
        end
        checks++;
        if (pix_x !== 8'd0 || pix_y !== 7'd0 || pix_colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: x=%0d y=%0d colour=%0d required 0 0 0", pix_x, pix_y, pix_colour);
        end
        resetn = 1'b1;
        step(); step();
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b required 0 0", pix_valid, busy);
        end
        $display("reset checked");
    endtask

    task automatic test_plot_writes();
        do_plot(0, 0, 1);
        do_plot(0, 1, 2);
        do_plot(2, 0, 4);
        do_plot(5, 3, 5);
        do_plot(7, 0, 3);
        do_plot(159, 119, 7);
        do_plot(160, 0, 7);   // would alias (0,1) if not dropped
        do_plot(0, 120, 7);
        step();
    endtask

    task automatic test_raster_frame(input int frame);
        int n;
        int extra;
        int ec;
        if (frame == 1) begin
            pix_ready = 1'b1;
            scan_en   = 1'b1;
        end
        extra = 0;
        for (int idx = 0; idx < DEPTH; idx++) begin
            wait_valid(n);
            checks++;
            if (pix_valid !== 1'b1) begin
                errors++;
                $display("FAIL valid_timeout: frame=%0d idx=%0d valid=%b required 1", frame, idx, pix_valid);
                return;
            end
            checks++;
            if (extra + n != ((frame == 1 && idx == 0) ? 2 : 1)) begin
                errors++;
                $display("FAIL pixel_gap: frame=%0d idx=%0d got %0d cycles required %0d", frame, idx,
                         extra + n, (frame == 1 && idx == 0) ? 2 : 1);
            end
            checks++;
            if (pix_x !== 8'(idx % WIDTH) || pix_y !== 7'(idx / WIDTH) || busy !== 1'b1) begin
                errors++;
                $display("FAIL coords: frame=%0d idx=%0d got (%0d,%0d) busy=%b required (%0d,%0d) busy=1",
                         frame, idx, pix_x, pix_y, busy, idx % WIDTH, idx / WIDTH);
            end
            checks++;
            if (pix_last !== (idx == DEPTH - 1)) begin
                errors++;
                $display("FAIL pix_last: frame=%0d idx=%0d got %b required %b", frame, idx, pix_last, idx == DEPTH - 1);
            end
            ec = expected_colour(frame, idx);
            if (ec >= 0) begin
                checks++;
                if (pix_colour !== 3'(ec)) begin
                    errors++;
                    $display("FAIL colour: frame=%0d idx=%0d got %0d required %0d", frame, idx, pix_colour, ec);
                end
                $display("pixel frame=%0d (%0d,%0d) colour=%0d last=%b", frame, pix_x, pix_y, pix_colour, pix_last);
            end
            if (frame == 1 && idx == 2) begin
                pix_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    if (s == 3) begin
                        plot = 1'b1; x = 8'd2; y = 7'd0; colour = 3'd1;
                    end
                    step();
                    plot = 1'b0;
                    checks++;
                    if (pix_valid !== 1'b1 || pix_x !== 8'd2 || pix_y !== 7'd0 || pix_colour !== 3'd4) begin
                        errors++;
                        $display("FAIL stall_hold: cycle=%0d valid=%b (%0d,%0d) colour=%0d required 1 (2,0) 4",
                                 s, pix_valid, pix_x, pix_y, pix_colour);
                    end
                end
                $display("stall of 10 cycles held at (2,0)");
                pix_ready = 1'b1;
            end
            if (frame == 2 && idx == 100) begin
                scan_en = 1'b0;
            end
            step();
            extra = 0;
            checks++;
            if (pix_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_drop: frame=%0d idx=%0d valid=%b required 0", frame, idx, pix_valid);
            end
            if (frame == 1 && idx == 6) begin
                // Engine is now in READ for (7,0); write the same address this cycle.
                plot = 1'b1; x = 8'd7; y = 7'd0; colour = 3'd6;
                step();
                plot = 1'b0;
                extra = 1;
            end
        end
        if (frame == 1) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_between_frames: got %b required 1", busy);
            end
            $display("frame 1 done, chaining into frame 2");
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_after_frame: got %b required 0", busy);
            end
            for (int s = 0; s < 5; s++) step();
            checks++;
            if (pix_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_frame: valid=%b busy=%b required 0 0", pix_valid, busy);
            end
            $display("frame 2 done, engine idle");
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        pix_ready = 1'b1;
        scan_en   = 1'b1;
        wait_valid(n);
        step();
        wait_valid(n);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || pix_x !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b x=%0d required 0 0 0", pix_valid, busy, pix_x);
        end
        scan_en = 1'b0;
        step();
        resetn  = 1'b1;
        step();
        scan_en = 1'b1;
        wait_valid(n);
        checks++;
        if (n != 2 || pix_x !== 8'd0 || pix_y !== 7'd0 || pix_colour !== 3'd1) begin
            errors++;
            $display("FAIL ram_retained: cycles=%0d (%0d,%0d) colour=%0d required 2 (0,0) 1", n, pix_x, pix_y, pix_colour);
        end
        $display("reset mid-frame, restart pixel (0,0) colour=%0d", pix_colour);
        scan_en = 1'b0;
        resetn  = 1'b0;
        step();
        resetn  = 1'b1;
        step();
    endtask

`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
    task automatic test_clear();
        int n;
        clear_req    = 1'b1;
        clear_colour = 3'd2;
        step();
        clear_req    = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_busy: got %b required 1", busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 25000) begin
            if (n == 100) clear_req = 1'b1;
            if (n == 101) clear_req = 1'b0;
            if (n == 10000) begin
                plot = 1'b1; x = 8'd3; y = 7'd0; colour = 3'd5;
                scan_en = 1'b1;
            end
            if (n == 10001) plot = 1'b0;
            step();
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_length: got %0d cycles required %0d", n, DEPTH);
        end
        $display("clear ran %0d cycles", n);
        for (int idx = 0; idx < 5; idx++) begin
            wait_valid(n);
            checks++;
            if (pix_valid !== 1'b1 || pix_x !== 8'(idx) || pix_colour !== 3'd2) begin
                errors++;
                $display("FAIL clear_readback: idx=%0d valid=%b x=%0d colour=%0d required 1 %0d 2",
                         idx, pix_valid, pix_x, pix_colour, idx);
            end
            step();
        end
        scan_en = 1'b0;
        resetn  = 1'b0;
        step();
        resetn  = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_plot_writes();
        test_raster_frame(1);
        test_raster_frame(2);
        test_reset_midframe();
`ifdef PLOT_FRAMEBUFFER_CLEAR_EN
        test_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
